// File: rtl/avalon_mem_bank_responder.sv
// Avalon-MM responder emulating one local-memory bank on inferred RAM.
// Burst writes with byte enables, queued burst reads, two-cycle read return.
module avalon_mem_bank_responder #(
    parameter int ADDR_WIDTH      = 27,
    parameter int DATA_WIDTH      = 512,
    parameter int BURST_CNT_WIDTH = 7,
    parameter int MEM_ADDR_WIDTH  = 10,
    parameter int RD_CMD_DEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       waitrequest,
    output logic [DATA_WIDTH-1:0]      readdata,
    output logic                       readdatavalid,
    input  logic [ADDR_WIDTH-1:0]      address,
    input  logic                       read,
    input  logic                       write,
    input  logic [BURST_CNT_WIDTH-1:0] burstcount,
    input  logic [DATA_WIDTH-1:0]      writedata,
    input  logic [DATA_WIDTH/8-1:0]    byteenable,
    output logic                       protocol_error
);

    localparam int BE_W    = DATA_WIDTH / 8;
    localparam int PTR_W   = $clog2(RD_CMD_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int MEM_DEP = 1 << MEM_ADDR_WIDTH;

    localparam logic [BURST_CNT_WIDTH-1:0] BC_ONE = 1;
    localparam logic [BURST_CNT_WIDTH-1:0] BC_MAX = BC_ONE << (BURST_CNT_WIDTH - 1);
    localparam logic [MEM_ADDR_WIDTH-1:0]  A_ONE  = 1;
    localparam logic [PTR_W-1:0]           P_ONE  = 1;
    localparam logic [CNT_W-1:0]           C_ONE  = 1;
    localparam logic [CNT_W-1:0]           C_FULL = CNT_W'(RD_CMD_DEPTH);

    localparam logic [0:0] WR_IDLE  = 1'b0;
    localparam logic [0:0] WR_BURST = 1'b1;

    logic [DATA_WIDTH-1:0] mem [0:MEM_DEP-1];

    logic [0:0]                 wr_state;
    logic [MEM_ADDR_WIDTH-1:0]  wr_addr;
    logic [BURST_CNT_WIDTH-1:0] wr_left;

    logic [MEM_ADDR_WIDTH-1:0]  fifo_addr [0:RD_CMD_DEPTH-1];
    logic [BURST_CNT_WIDTH-1:0] fifo_bc   [0:RD_CMD_DEPTH-1];
    logic [PTR_W-1:0]           push_ptr;
    logic [PTR_W-1:0]           pop_ptr;
    logic [CNT_W-1:0]           fifo_cnt;

    logic                       eng_active;
    logic [MEM_ADDR_WIDTH-1:0]  eng_addr;
    logic [BURST_CNT_WIDTH-1:0] eng_left;

    logic fifo_empty, fifo_full, rd_busy, wr_idle;
    logic cmd_cycle, bc_bad, req, err, rd_acc, wr_acc;
    logic push, pop, issue, eng_last;
    logic [MEM_ADDR_WIDTH-1:0]  wr_beat_addr;
    logic [MEM_ADDR_WIDTH-1:0]  head_addr;
    logic [BURST_CNT_WIDTH-1:0] head_bc;
    logic [MEM_ADDR_WIDTH-1:0]  issue_addr;
    logic                       unused_addr_bits;

    assign unused_addr_bits = ^address[ADDR_WIDTH-1:MEM_ADDR_WIDTH];

    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == C_FULL);
    assign rd_busy    = !fifo_empty || eng_active || readdatavalid;
    assign wr_idle    = (wr_state == WR_IDLE);

    // Holding a new write burst until reads drain keeps reads from seeing later writes.
    assign waitrequest = reset || fifo_full || (write && wr_idle && rd_busy);

    assign cmd_cycle = read || (write && wr_idle);
    assign bc_bad    = (burstcount == '0) || (burstcount > BC_MAX);
    assign req       = (read || write) && !waitrequest;
    assign err       = req && ((read && write) || (read && !wr_idle) || (cmd_cycle && bc_bad));
    assign rd_acc    = req && read && !err;
    assign wr_acc    = req && write && !err;

    assign wr_beat_addr = wr_idle ? address[MEM_ADDR_WIDTH-1:0] : wr_addr + A_ONE;

    assign head_addr = fifo_addr[pop_ptr];
    assign head_bc   = fifo_bc[pop_ptr];
    assign eng_last  = eng_active && (eng_left == BC_ONE);
    assign issue     = eng_active || !fifo_empty;
    // An idle engine issues straight from the FIFO head; a busy one chains on its last beat.
    assign pop        = !fifo_empty && (!eng_active || eng_last);
    assign issue_addr = eng_active ? eng_addr : head_addr;
    assign push       = rd_acc;

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            for (int i = 0; i < BE_W; i++) begin
                if (byteenable[i]) begin
                    mem[wr_beat_addr][i*8 +: 8] <= writedata[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[push_ptr] <= address[MEM_ADDR_WIDTH-1:0];
            fifo_bc[push_ptr]   <= burstcount;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_state       <= WR_IDLE;
            wr_addr        <= '0;
            wr_left        <= '0;
            push_ptr       <= '0;
            pop_ptr        <= '0;
            fifo_cnt       <= '0;
            eng_active     <= 1'b0;
            eng_addr       <= '0;
            eng_left       <= '0;
            readdatavalid  <= 1'b0;
            readdata       <= '0;
            protocol_error <= 1'b0;
        end else begin
            if (err) begin
                protocol_error <= 1'b1;
            end

            if (wr_acc) begin
                wr_addr <= wr_beat_addr;
                if (wr_idle) begin
                    wr_left  <= burstcount - BC_ONE;
                    wr_state <= (burstcount == BC_ONE) ? WR_IDLE : WR_BURST;
                end else begin
                    wr_left <= wr_left - BC_ONE;
                    if (wr_left == BC_ONE) begin
                        wr_state <= WR_IDLE;
                    end
                end
            end

            if (push) begin
                push_ptr <= push_ptr + P_ONE;
            end
            if (pop) begin
                pop_ptr <= pop_ptr + P_ONE;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + C_ONE;
                2'b01:   fifo_cnt <= fifo_cnt - C_ONE;
                default: fifo_cnt <= fifo_cnt;
            endcase

            if (pop) begin
                if (eng_active) begin
                    eng_addr   <= head_addr;
                    eng_left   <= head_bc;
                    eng_active <= 1'b1;
                end else begin
                    eng_addr   <= head_addr + A_ONE;
                    eng_left   <= head_bc - BC_ONE;
                    eng_active <= (head_bc != BC_ONE);
                end
            end else if (eng_active) begin
                eng_addr <= eng_addr + A_ONE;
                eng_left <= eng_left - BC_ONE;
                if (eng_last) begin
                    eng_active <= 1'b0;
                end
            end

            readdatavalid <= issue;
            if (issue) begin
                readdata <= mem[issue_addr];
            end
        end
    end

endmodule

// File: tb/tb_avalon_mem_bank_responder.sv
// Directed bench for avalon_mem_bank_responder.
// Linear steps with immediate assertions at each comparison.
module tb_avalon_mem_bank_responder;

    localparam int AW  = 27;
    localparam int DW  = 512;
    localparam int BW  = 7;
    localparam int BEW = DW / 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           waitrequest;
    logic [DW-1:0]  readdata;
    logic           readdatavalid;
    logic [AW-1:0]  address;
    logic           read;
    logic           write;
    logic [BW-1:0]  burstcount;
    logic [DW-1:0]  writedata;
    logic [BEW-1:0] byteenable;
    logic           protocol_error;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int cyc    = 0;
    int last_cyc = 0;
    int wr_acc_cyc = 0;
    int rd_acc_cyc = 0;
    int seen;
    logic [DW-1:0] exp_q [$];

    localparam logic [DW-1:0] A5S = {64{8'hA5}};
    localparam logic [DW-1:0] EES = {64{8'hEE}};
    localparam logic [BEW-1:0] BE_ALL = '1;

    avalon_mem_bank_responder dut (
        .clk            (clk),
        .reset          (reset),
        .waitrequest    (waitrequest),
        .readdata       (readdata),
        .readdatavalid  (readdatavalid),
        .address        (address),
        .read           (read),
        .write          (write),
        .burstcount     (burstcount),
        .writedata      (writedata),
        .byteenable     (byteenable),
        .protocol_error (protocol_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) begin passes++; end
        else begin fails++; $error("FAIL %s: got %b want %b", tag, obs, exp); end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) begin passes++; end
        else begin fails++; $error("FAIL %s: got %0d want %0d", tag, obs, exp); end
    endtask

    task automatic chk_data(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) begin passes++; end
        else begin fails++; $error("FAIL %s: got %0h want %0h", tag, obs, exp); end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (waitrequest !== 1'b0 && n < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (n == 100) begin
            checks++;
            fails++;
            $error("FAIL %s: waitrequest got 1 want 0 within 100 cycles", tag);
        end
    endtask

    task automatic write_burst(input logic [AW-1:0] a, input int n,
                               input logic [DW-1:0] base, input logic [BEW-1:0] be);
        for (int i = 0; i < n; i++) begin
            address    = a;
            burstcount = BW'(n);
            writedata  = base + DW'(i);
            byteenable = be;
            write      = 1'b1;
            #1;
            wait_ready("wr_wait");
            wr_acc_cyc = cyc;
            @(posedge clk);
            #1;
        end
        write = 1'b0;
    endtask

    task automatic issue_read(input logic [AW-1:0] a, input int n);
        address    = a;
        burstcount = BW'(n);
        read       = 1'b1;
        #1;
        wait_ready("rd_wait");
        rd_acc_cyc = cyc;
        @(posedge clk);
        #1;
        read = 1'b0;
    endtask

    task automatic drain(input int n);
        int w = 0;
        while (readdatavalid !== 1'b1 && w < 64) begin
            step();
            w++;
        end
        if (w == 64) begin
            checks++;
            fails++;
            $error("FAIL drain: readdatavalid got 0 want 1 within 64 cycles");
        end
        for (int i = 0; i < n; i++) begin
            chk_bit("beat_valid", readdatavalid, 1'b1);
            chk_data("beat_data", readdata, exp_q.pop_front());
            last_cyc = cyc;
            step();
        end
    endtask

    task automatic count_returns(input int n);
        seen = 0;
        repeat (n) begin
            if (readdatavalid === 1'b1) seen++;
            step();
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; read = 1'b0; write = 1'b0; address = '0;
        burstcount = '0; writedata = '0; byteenable = '0;
        repeat (3) step();
        chk_bit("rst_wait", waitrequest, 1'b1);
        chk_bit("rst_rdv", readdatavalid, 1'b0);
        chk_data("rst_rdata", readdata, '0);
        chk_bit("rst_perr", protocol_error, 1'b0);
        reset = 1'b0;
        #1;
        chk_bit("idle_wait", waitrequest, 1'b0);

        // single write then single read, latency T+2
        write_burst(27'd5, 1, A5S, BE_ALL);
        issue_read(27'd5, 1);
        chk_bit("lat_t1", readdatavalid, 1'b0);
        step();
        chk_bit("lat_t2", readdatavalid, 1'b1);
        chk_int("lat_cyc", cyc, rd_acc_cyc + 2);
        chk_data("lat_data", readdata, A5S);
        step();
        chk_bit("lat_t3", readdatavalid, 1'b0);

        // byte-enable merge
        write_burst(27'd8, 1, {DW{1'b1}}, BE_ALL);
        write_burst(27'd8, 1, '0, 64'h1);
        exp_q.push_back({{63{8'hFF}}, 8'h00});
        issue_read(27'd8, 1);
        drain(1);

        // write burst wrapping past the top of the RAM
        write_burst(27'd1022, 4, DW'(1), BE_ALL);
        for (int i = 1; i <= 4; i++) exp_q.push_back(DW'(i));
        issue_read(27'd1022, 4);
        drain(4);
        exp_q.push_back(DW'(3));
        exp_q.push_back(DW'(4));
        issue_read(27'd0, 2);
        drain(2);

        // queued reads, full FIFO, stalled write
        write_burst(27'd200, 40, DW'(100), BE_ALL);
        for (int k = 0; k < 5; k++) begin
            int a;
            case (k)
                0: a = 232;
                1: a = 200;
                2: a = 216;
                3: a = 208;
                default: a = 224;
            endcase
            for (int j = 0; j < 8; j++) exp_q.push_back(DW'(100 + a - 200 + j));
        end
        fork
            begin
                issue_read(27'd232, 8);
                issue_read(27'd200, 8);
                issue_read(27'd216, 8);
                issue_read(27'd208, 8);
                issue_read(27'd224, 8);
                address = 27'd300;
                burstcount = 7'd8;
                read = 1'b1;
                #1;
                chk_bit("fifo_full_wait", waitrequest, 1'b1);
                @(posedge clk);
                #1;
                read = 1'b0;
                write_burst(27'd232, 1, EES, BE_ALL);
            end
            begin
                drain(40);
            end
        join
        chk_int("wr_stall_cyc", wr_acc_cyc, last_cyc + 1);
        count_returns(3);
        chk_int("no_extra_beats", seen, 0);
        chk_bit("q_perr", protocol_error, 1'b0);
        exp_q.push_back(EES);
        issue_read(27'd232, 1);
        drain(1);

        // read and write together
        address = 27'd5; burstcount = 7'd1; writedata = {64{8'h11}};
        byteenable = BE_ALL; read = 1'b1; write = 1'b1;
        step();
        read = 1'b0; write = 1'b0;
        chk_bit("rw_perr", protocol_error, 1'b1);
        count_returns(4);
        chk_int("rw_noret", seen, 0);
        exp_q.push_back(A5S);
        issue_read(27'd5, 1);
        drain(1);
        pulse_reset();
        chk_bit("rst_clears_perr", protocol_error, 1'b0);

        // read in the middle of a write burst
        address = 27'd400; burstcount = 7'd4; writedata = DW'(16);
        byteenable = BE_ALL; write = 1'b1;
        #1;
        chk_bit("wb_first_wait", waitrequest, 1'b0);
        step();
        write = 1'b0; read = 1'b1; address = 27'd400; burstcount = 7'd1;
        step();
        read = 1'b0;
        chk_bit("midburst_perr", protocol_error, 1'b1);
        for (int i = 1; i < 4; i++) begin
            address = '0; burstcount = '0; writedata = DW'(16 + i); write = 1'b1;
            step();
        end
        write = 1'b0;
        for (int i = 0; i < 4; i++) exp_q.push_back(DW'(16 + i));
        issue_read(27'd400, 4);
        drain(4);
        pulse_reset();

        // illegal burstcounts; flag stays until reset
        address = 27'd5; burstcount = 7'd0; read = 1'b1;
        step();
        read = 1'b0;
        chk_bit("bc0_perr", protocol_error, 1'b1);
        count_returns(4);
        chk_int("bc0_noret", seen, 0);
        exp_q.push_back(A5S);
        issue_read(27'd5, 1);
        drain(1);
        chk_bit("perr_sticky", protocol_error, 1'b1);
        pulse_reset();
        chk_bit("perr_cleared", protocol_error, 1'b0);
        address = 27'd5; burstcount = 7'd65; writedata = {64{8'h33}};
        byteenable = BE_ALL; write = 1'b1;
        step();
        write = 1'b0;
        chk_bit("bc65_perr", protocol_error, 1'b1);
        exp_q.push_back(A5S);
        issue_read(27'd5, 1);
        drain(1);
        pulse_reset();

        // reset during the third beat of an 8-beat return
        issue_read(27'd200, 8);
        step();
        chk_data("rst_mid_b1", readdata, DW'(100));
        step();
        step();
        chk_bit("rst_mid_b3v", readdatavalid, 1'b1);
        chk_data("rst_mid_b3", readdata, DW'(102));
        reset = 1'b1;
        step();
        chk_bit("rst_mid_rdv0", readdatavalid, 1'b0);
        chk_bit("rst_mid_wait", waitrequest, 1'b1);
        step();
        reset = 1'b0;
        count_returns(10);
        chk_int("rst_mid_discard", seen, 0);
        issue_read(27'd5, 1);
        chk_bit("post_rst_t1", readdatavalid, 1'b0);
        step();
        chk_bit("post_rst_t2", readdatavalid, 1'b1);
        chk_data("post_rst_data", readdata, A5S);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/avalon_mem_bank_responder.md
Name: avalon_mem_bank_responder

Overview:
- Avalon-MM slave (responder) that emulates one local-memory bank, using an inferred on-chip RAM.
- It is the far end of the avalon_mem_if that the platform shim hands to an AFU as a master.
- Used in ASE/unit benches and on platforms without physical local memory, so AFUs with a local-memory requirement run unmodified.
- Supports burst reads and writes, byte enables, queued read commands and fixed-latency pipelined read return.

Parameters:
- ADDR_WIDTH, 27: width of the word address port, matching the bank interface.
- DATA_WIDTH, 512: data bus width in bits; byteenable is DATA_WIDTH/8.
- BURST_CNT_WIDTH, 7: burstcount width; legal counts are 1..2**(BURST_CNT_WIDTH-1).
- MEM_ADDR_WIDTH, 10: log2 of the emulated RAM depth in words; only address[MEM_ADDR_WIDTH-1:0] is used.
- RD_CMD_DEPTH, 4: read command FIFO entries; power of 2, at least 2.

Ports:
- clk, in, 1: single clock for all logic.
- reset, in, 1: synchronous, active-high reset.
- waitrequest, out, 1: slave stall.
- readdata, out, DATA_WIDTH: read return data.
- readdatavalid, out, 1: readdata valid this cycle.
- address, in, ADDR_WIDTH: word address of the first beat.
- read, in, 1: read command request.
- write, in, 1: write beat request.
- burstcount, in, BURST_CNT_WIDTH: beats in the burst; sampled on the first beat only.
- writedata, in, DATA_WIDTH: write data.
- byteenable, in, DATA_WIDTH/8: per-byte write mask.
- protocol_error, out, 1: sticky error flag, cleared only by reset.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: waitrequest=1 while reset is high; readdatavalid=0; readdata=0; protocol_error=0; read FIFO empty; both FSMs idle. RAM contents are not reset.
- In-flight state on reset: a reset mid-burst discards the in-flight write remainder, queued reads and pending returns. No readdatavalid is asserted in any cycle after reset is sampled high.
- Acceptance: a beat or command is accepted in a cycle where (read|write) && !waitrequest.
- waitrequest (combinational from registered state and inputs) = reset | rd_fifo_full | (write && wr_state==WR_IDLE && rd_busy).
  - rd_busy = FIFO non-empty, or read engine active, or return pipeline holds a beat.
  - Effect: a new write burst starts only once all earlier reads have returned, so reads never observe later writes.
  - Continuation beats of an open write burst are never stalled.
- Write FSM, WR_IDLE:
  - An accepted write latches addr = address[MEM_ADDR_WIDTH-1:0] and remaining = burstcount-1.
  - The beat is written to the RAM that cycle, masked by byteenable.
  - If remaining != 0, go to WR_BURST.
- Write FSM, WR_BURST:
  - Each accepted write increments addr modulo 2**MEM_ADDR_WIDTH, writes the beat and decrements remaining.
  - The beat with remaining==0 returns the FSM to WR_IDLE.
  - address and burstcount are ignored in WR_BURST.
- Read commands: an accepted read pushes {addr, burstcount} into the FIFO. The read engine pops a command when idle, or on the last beat of the current burst with no bubble.
- Read engine: issues one RAM read per cycle, incrementing addr with wrap. The RAM output is registered once.
- Read latency: with an empty FIFO and idle engine, a read accepted in cycle T gives the first readdatavalid in T+2. The remaining beats follow in consecutive cycles.
- Back-to-back read bursts return with zero idle cycles between them.
- Read ordering: returns are strictly in command order. Each beat reflects all writes accepted before the read command.
- Protocol errors set protocol_error and drop the offending command without accepting it, in these cases:
  - read && write in the same cycle;
  - read asserted while wr_state==WR_BURST;
  - burstcount==0, or burstcount > 2**(BURST_CNT_WIDTH-1), on a command cycle.
  - These checks are evaluated only when !waitrequest.
- Concurrency: a read accepted while a read return is in progress is legal and queues.
- FIFO boundaries:
  - Full: waitrequest is high and no push happens.
  - Push and pop in the same cycle at full: the push is still refused, because waitrequest was already high.
- Counters: beat counters are BURST_CNT_WIDTH bits. The address counter is MEM_ADDR_WIDTH bits and wraps silently.

Test Plan:
- Reset, then a single write: addr 5, burstcount 1, data 0xA5 in all bytes, byteenable all ones. Then read addr 5, burstcount 1 accepted at T -> readdatavalid at T+2 only, readdata = all 0xA5.
- Byte-enable merge: write 0xFF.. to addr 8, then write 0x00.. with byteenable=0x...0001. Read addr 8 -> byte0 = 0x00, all other bytes 0xFF.
- Write burst with wrap: addr 1022, burstcount 4, data 1,2,3,4 (MEM_ADDR_WIDTH=10). Read addr 1022, burstcount 4 -> 4 consecutive beats 1,2,3,4; words 0 and 1 hold 3 and 4.
- Queueing and full FIFO:
  - Issue 5 reads of burstcount 8 back-to-back -> waitrequest high once 4 commands are queued.
  - 40 consecutive readdatavalid cycles with no gaps, in command order.
  - A write presented during the returns stalls until the last beat plus 1 cycle.
- Protocol errors:
  - read && write together -> protocol_error=1, no RAM change, no return.
  - A read mid write burst sets protocol_error, and the write burst still completes correctly.
  - burstcount=0 sets protocol_error.
  - Only reset clears protocol_error.
- Reset mid-operation: assert reset during beat 3 of an 8-beat read return -> readdatavalid=0 from the next cycle on. After release, the first new read returns at T+2 with correct data.
